// File: rtl/ref_sc_fifo_commit_block_ram.sv
// Single-clock FIFO on a block RAM. Writes are speculative until committed, and
// uncommitted words can be dropped. The read side adds an advance pointer.
module ref_sc_fifo_commit_block_ram #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 72,
    parameter int INC_WIDTH     = ADDR_WIDTH - 1,
    parameter int EN_LOOK_AHEAD = 0,
    parameter int AF_THRESH     = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    input  logic                  wr_discard,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_empty,
    output logic                  rd_underflow,
    input  logic                  rd_adv_en,
    input  logic [INC_WIDTH-1:0]  rd_adv_inc,
    output logic [ADDR_WIDTH:0]   rd_adv_level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // One extra MSB separates a full buffer from an empty one.
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH_LVL = ptr_t'(DEPTH);
    localparam ptr_t AF_LVL    = ptr_t'(AF_THRESH);

    ptr_t wr_addr_q, wr_addr_d;
    ptr_t cm_addr_q, cm_addr_d;
    ptr_t rd_addr_q, rd_addr_d;
    ptr_t rd_adv_addr_q, rd_adv_addr_d;
    ptr_t wr_level_q, wr_level_d;
    ptr_t rd_level_q, rd_level_d;
    ptr_t rd_adv_level_q, rd_adv_level_d;

    logic wr_full_q;
    logic wr_almost_full_q;
    logic wr_overflow_q;
    logic rd_empty_q;
    logic rd_underflow_q;
    logic wr_acc;
    logic rd_acc;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves a latch behind.
        wr_acc        = wr_en && !wr_full_q;
        rd_acc        = rd_en && !rd_empty_q;
        wr_addr_d     = wr_addr_q;
        cm_addr_d     = cm_addr_q;
        rd_adv_addr_d = rd_adv_addr_q;

        if (wr_discard && !wr_commit) begin
            wr_addr_d = cm_addr_q;
        end else if (wr_acc) begin
            wr_addr_d = wr_addr_q + ptr_t'(1);
        end

        // Commit publishes this cycle's accepted word as well.
        if (wr_commit) begin
            cm_addr_d = wr_addr_q + ptr_t'(wr_acc);
        end

        rd_addr_d = rd_addr_q + ptr_t'(rd_acc);

        if (rd_adv_en) begin
            rd_adv_addr_d = rd_adv_addr_q + ptr_t'(rd_adv_inc);
        end

        // Read-side levels use the current commit pointer. A commit therefore
        // becomes visible one cycle after its RAM write has landed.
        wr_level_d     = wr_addr_d - rd_addr_d;
        rd_level_d     = cm_addr_q - rd_addr_d;
        rd_adv_level_d = cm_addr_q - rd_adv_addr_d;

        ram_rd_addr = (EN_LOOK_AHEAD != 0) ? rd_addr_d[ADDR_WIDTH-1:0]
                                           : rd_addr_q[ADDR_WIDTH-1:0];
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q        <= '0;
            cm_addr_q        <= '0;
            rd_addr_q        <= '0;
            rd_adv_addr_q    <= '0;
            wr_level_q       <= '0;
            rd_level_q       <= '0;
            rd_adv_level_q   <= '0;
            wr_full_q        <= 1'b0;
            wr_almost_full_q <= 1'b0;
            wr_overflow_q    <= 1'b0;
            rd_empty_q       <= 1'b1;
            rd_underflow_q   <= 1'b0;
        end else begin
            wr_addr_q        <= wr_addr_d;
            cm_addr_q        <= cm_addr_d;
            rd_addr_q        <= rd_addr_d;
            rd_adv_addr_q    <= rd_adv_addr_d;
            wr_level_q       <= wr_level_d;
            rd_level_q       <= rd_level_d;
            rd_adv_level_q   <= rd_adv_level_d;
            wr_full_q        <= (wr_level_d == DEPTH_LVL);
            wr_almost_full_q <= (wr_level_d >= AF_LVL);
            wr_overflow_q    <= wr_overflow_q | (wr_en & wr_full_q);
            rd_empty_q       <= (rd_level_d == '0);
            rd_underflow_q   <= rd_underflow_q | (rd_en & rd_empty_q);
        end
    end

    // NOTE: RAM contents and its output register are not reset, so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
        rd_data_q <= mem[ram_rd_addr];
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_en && wr_full_q)
                $display("ERROR: %m write overflow");
            if (rd_en && rd_empty_q)
                $display("ERROR: %m read underflow");
            if (rd_adv_level_d > DEPTH_LVL)
                $display("ERROR: %m rd_adv_addr passed cm_addr");
        end else if (INC_WIDTH >= ADDR_WIDTH) begin
            $display("ERROR: %m INC_WIDTH must be less than ADDR_WIDTH");
        end
    end
`endif

    assign wr_level       = wr_level_q;
    assign wr_full        = wr_full_q;
    assign wr_almost_full = wr_almost_full_q;
    assign wr_overflow    = wr_overflow_q;
    assign rd_data        = rd_data_q;
    assign rd_level       = rd_level_q;
    assign rd_empty       = rd_empty_q;
    assign rd_underflow   = rd_underflow_q;
    assign rd_adv_level   = rd_adv_level_q;

endmodule

// File: tb/tb_ref_sc_fifo_commit_block_ram.sv
// Bench for the commit FIFO: one instance without look-ahead and one with it, on shared inputs.
// Directed tables cover the named corner cases; a queue model checks random traffic.
module tb_ref_sc_fifo_commit_block_ram;

    localparam int AW = 3;
    localparam int DW = 72;
    localparam int IW = 2;
    localparam int LW = AW + 1;
    localparam int DEPTH = 8;
    localparam int AF = 6;

    typedef logic [DW-1:0] data_t;

    typedef struct {
        bit        we;
        data_t     wd;
        bit        cm;
        bit        dc;
        bit        re;
        int        wl;
        int        rl;
        bit        ovf;
        bit        unf;
        bit [1:0]  dmask;
        data_t     dexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    data_t wr_data = '0;
    logic wr_commit = 1'b0;
    logic wr_discard = 1'b0;
    logic rd_en = 1'b0;
    logic rd_adv_en = 1'b0;
    logic [IW-1:0] rd_adv_inc = '0;

    logic [1:0][LW-1:0] wr_level;
    logic [1:0][LW-1:0] rd_level;
    logic [1:0][LW-1:0] rd_adv_level;
    logic [1:0]         wr_full;
    logic [1:0]         wr_almost_full;
    logic [1:0]         wr_overflow;
    logic [1:0]         rd_empty;
    logic [1:0]         rd_underflow;
    logic [1:0][DW-1:0] rd_data;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ref_sc_fifo_commit_block_ram #(
            .ADDR_WIDTH   (AW),
            .DATA_WIDTH   (DW),
            .INC_WIDTH    (IW),
            .EN_LOOK_AHEAD(g),
            .AF_THRESH    (AF)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .wr_en         (wr_en),
            .wr_data       (wr_data),
            .wr_commit     (wr_commit),
            .wr_discard    (wr_discard),
            .wr_level      (wr_level[g]),
            .wr_full       (wr_full[g]),
            .wr_almost_full(wr_almost_full[g]),
            .wr_overflow   (wr_overflow[g]),
            .rd_en         (rd_en),
            .rd_data       (rd_data[g]),
            .rd_level      (rd_level[g]),
            .rd_empty      (rd_empty[g]),
            .rd_underflow  (rd_underflow[g]),
            .rd_adv_en     (rd_adv_en),
            .rd_adv_inc    (rd_adv_inc),
            .rd_adv_level  (rd_adv_level[g])
        );
    end

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    // Reference model: committed and uncommitted words as queues, counts as plain integers.
    data_t cq[$];
    data_t uq[$];
    int    rl_m, wl_m, cm_tot, adv_tot, al_m;
    bit    ovf_m, unf_m, prev_rd;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int wl, input int rl, input bit ovf, input bit unf);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s.d%0d.wr_level", tag, g), wr_level[g], 128'(wl));
            check($sformatf("%s.d%0d.rd_level", tag, g), rd_level[g], 128'(rl));
            check($sformatf("%s.d%0d.rd_empty", tag, g), rd_empty[g], 128'(rl == 0));
            check($sformatf("%s.d%0d.wr_full", tag, g), wr_full[g], 128'(wl == DEPTH));
            check($sformatf("%s.d%0d.wr_almost_full", tag, g), wr_almost_full[g], 128'(wl >= AF));
            check($sformatf("%s.d%0d.wr_overflow", tag, g), wr_overflow[g], 128'(ovf));
            check($sformatf("%s.d%0d.rd_underflow", tag, g), rd_underflow[g], 128'(unf));
        end
    endtask

    task automatic check_adv(input string tag, input int al);
        for (int g = 0; g < 2; g++)
            check($sformatf("%s.d%0d.rd_adv_level", tag, g), rd_adv_level[g], 128'(al & 15));
    endtask

    task automatic idle();
        wr_en = 1'b0;
        wr_commit = 1'b0;
        wr_discard = 1'b0;
        rd_en = 1'b0;
        rd_adv_en = 1'b0;
        rd_adv_inc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cq.delete();
        uq.delete();
        rl_m = 0; wl_m = 0; cm_tot = 0; adv_tot = 0; al_m = 0;
        ovf_m = 1'b0; unf_m = 1'b0; prev_rd = 1'b0;
    endtask

    function automatic vec_t v(bit we, data_t wd, bit cm, bit dc, bit re, int wl, int rl,
                               bit ovf, bit unf, bit [1:0] dm, data_t de);
        vec_t r;
        r.we = we; r.wd = wd; r.cm = cm; r.dc = dc; r.re = re;
        r.wl = wl; r.rl = rl; r.ovf = ovf; r.unf = unf; r.dmask = dm; r.dexp = de;
        return r;
    endfunction

    function automatic data_t dv(int base, int i);
        return data_t'(base) + data_t'(i);
    endfunction

    // Rows are driven on a falling edge; expectations are for the cycle after the next rising edge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].we;
            wr_data = tbl[i].wd;
            wr_commit = tbl[i].cm;
            wr_discard = tbl[i].dc;
            rd_en = tbl[i].re;
            @(negedge clk);
            check_state($sformatf("%s[%0d]", tag, i), tbl[i].wl, tbl[i].rl, tbl[i].ovf, tbl[i].unf);
            for (int g = 0; g < 2; g++)
                if (tbl[i].dmask[g])
                    check($sformatf("%s[%0d].d%0d.rd_data", tag, i, g), rd_data[g], tbl[i].dexp);
        end
        idle();
    endtask

    task automatic model_step(input bit we, input data_t wd, input bit cm, input bit dc,
                              input bit re, input bit ae, input int inc);
        bit full;
        bit acc_w;
        bit acc_r;
        int cm_before;
        full  = (cq.size() + uq.size()) == DEPTH;
        acc_w = we && !full;
        acc_r = re && (rl_m != 0);
        ovf_m |= we && full;
        unf_m |= re && (rl_m == 0);
        if (acc_r) void'(cq.pop_front());
        rl_m = cq.size();
        cm_before = cm_tot;
        if (acc_w) uq.push_back(wd);
        if (cm) begin
            cm_tot += uq.size();
            foreach (uq[k]) cq.push_back(uq[k]);
            uq.delete();
        end else if (dc) begin
            uq.delete();
        end
        if (ae) adv_tot += inc;
        al_m = cm_before - adv_tot;
        wl_m = cq.size() + uq.size();
        prev_rd = acc_r;
    endtask

    initial begin
        idle();
        do_reset();
        check_state("reset", 0, 0, 1'b0, 1'b0);
        check_adv("reset", 0);

        // Three words committed on the third write, then read back in order.
        tbl.delete();
        tbl.push_back(v(1, 72'hA, 0, 0, 0, 1, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(1, 72'hB, 0, 0, 0, 2, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(1, 72'hC, 1, 0, 0, 3, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(0, '0,    0, 0, 0, 3, 3, 0, 0, 2'b11, 72'hA));
        tbl.push_back(v(0, '0,    0, 0, 1, 2, 2, 0, 0, 2'b10, 72'hB));
        tbl.push_back(v(0, '0,    0, 0, 0, 2, 2, 0, 0, 2'b11, 72'hB));
        tbl.push_back(v(0, '0,    0, 0, 1, 1, 1, 0, 0, 2'b10, 72'hC));
        tbl.push_back(v(0, '0,    0, 0, 0, 1, 1, 0, 0, 2'b11, 72'hC));
        tbl.push_back(v(0, '0,    0, 0, 1, 0, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(0, '0,    0, 0, 1, 0, 0, 0, 1, 2'b00, '0));
        run_table("commit3");

        // Five words dropped, then a fresh packet lands on the same addresses.
        do_reset();
        tbl.delete();
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, dv('hE00, i), 0, 0, 0, i + 1, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(0, '0, 0, 1, 0, 0, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(1, 72'hF0, 0, 0, 0, 1, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(1, 72'hF1, 1, 0, 0, 2, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(0, '0, 0, 0, 0, 2, 2, 0, 0, 2'b11, 72'hF0));
        tbl.push_back(v(0, '0, 0, 0, 1, 1, 1, 0, 0, 2'b10, 72'hF1));
        tbl.push_back(v(0, '0, 0, 0, 0, 1, 1, 0, 0, 2'b11, 72'hF1));
        run_table("discard");

        // Fill to full, overflow, then one read frees a slot.
        do_reset();
        tbl.delete();
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(1, dv('hD00, i), i == 7, 0, 0, i + 1, 0, 0, 0, 2'b00, '0));
        tbl.push_back(v(1, dv('hD00, 8), 0, 0, 0, 8, 8, 1, 0, 2'b11, dv('hD00, 0)));
        tbl.push_back(v(0, '0, 0, 0, 1, 7, 7, 1, 0, 2'b10, dv('hD00, 1)));
        tbl.push_back(v(0, '0, 0, 0, 0, 7, 7, 1, 0, 2'b11, dv('hD00, 1)));
        run_table("full");

        // Advance pointer jumps 3 past five committed words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = dv('h500, i);
            wr_commit = (i == 4);
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        check_state("adv.pre", 5, 5, 1'b0, 1'b0);
        check_adv("adv.pre", 5);
        rd_adv_en = 1'b1;
        rd_adv_inc = 2'd3;
        @(negedge clk);
        idle();
        check_state("adv.post", 5, 5, 1'b0, 1'b0);
        check_adv("adv.post", 2);

        // Asynchronous reset with three committed and two uncommitted words.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = dv('h300, i);
            wr_commit = (i == 2);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        check_state("mid.pre", 5, 3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_state("mid.rst", 0, 0, 1'b0, 1'b0);
        check_adv("mid.rst", 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_state("mid.post", 0, 0, 1'b0, 1'b0);

        // Random traffic across several pointer wraps, checked against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit    we, cm, dc, re, ae;
            int    inc;
            data_t wd;
            @(negedge clk);
            check_state($sformatf("rnd%0d", c), wl_m, rl_m, ovf_m, unf_m);
            check_adv($sformatf("rnd%0d", c), al_m);
            if (rl_m != 0) begin
                check($sformatf("rnd%0d.d1.rd_data", c), rd_data[1], cq[0]);
                if (!prev_rd)
                    check($sformatf("rnd%0d.d0.rd_data", c), rd_data[0], cq[0]);
            end
            we  = ($urandom_range(0, 99) < 65);
            cm  = ($urandom_range(0, 99) < 20);
            dc  = ($urandom_range(0, 99) < 8);
            re  = ($urandom_range(0, 99) < 50);
            ae  = ($urandom_range(0, 99) < 15);
            inc = $urandom_range(0, 3);
            wd  = {8'($urandom), $urandom, $urandom};
            wr_en = we;
            wr_data = wd;
            wr_commit = cm;
            wr_discard = dc;
            rd_en = re;
            rd_adv_en = ae;
            rd_adv_inc = IW'(inc);
            model_step(we, wd, cm, dc, re, ae, inc);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
